// File: rtl/unsat_clause_index_selector_pkg.sv
// Shared constants for the multi-channel unsatisfied-clause index selector:
// mode encodings, default LFSR seed and Galois tap masks.
package unsat_clause_index_selector_pkg;

    localparam logic [1:0] MODE_RANDOM = 2'b00;
    localparam logic [1:0] MODE_RR     = 2'b01;
    localparam logic [1:0] MODE_OLDEST = 2'b10;

    localparam logic [31:0] DEFAULT_LFSR_SEED = 32'hACE1_2468;

    // Right-shifting Galois masks: x^16+x^14+x^13+x^11+1 and x^32+x^22+x^2+x+1
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int width);
        return (width == 16) ? {16'h0000, LFSR_TAPS_16} : LFSR_TAPS_32;
    endfunction

endpackage

// File: rtl/unsat_clause_index_selector_lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load; load has priority over step.
module lfsr_galois #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = load_data;
        end else if (step) begin
            q_next = (q_reg >> 1) ^ (q_reg[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/unsat_clause_index_selector.sv
// Per-walker index selector: round-robin arbitration over channels, then a
// two-register pipeline producing a random, round-robin or oldest buffer index.
module unsat_clause_index_selector
    import unsat_clause_index_selector_pkg::*;
#(
    parameter int                BUFFER_DEPTH     = 2048,
    parameter int                RANDOM_NUM_WIDTH = 18,
    parameter int                NUM_CHANNELS     = 4,
    parameter int                LFSR_W           = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED        = LFSR_W'(DEFAULT_LFSR_SEED),
    localparam int               ADDR_W           = $clog2(BUFFER_DEPTH),
    localparam int               CH_W             = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CHANNELS-1:0]          req_valid,
    output logic [NUM_CHANNELS-1:0]          req_ready,
    input  logic [2*NUM_CHANNELS-1:0]        req_mode,
    input  logic [NUM_CHANNELS*(ADDR_W+1)-1:0] unsat_count,
    input  logic                             seed_wr,
    input  logic [LFSR_W-1:0]                seed_data,
    output logic                             sel_valid,
    input  logic                             sel_ready,
    output logic [CH_W-1:0]                  sel_channel,
    output logic [ADDR_W-1:0]                sel_index,
    output logic [CH_W+ADDR_W-1:0]           sel_addr,
    output logic                             sel_empty
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int PROD_W = RANDOM_NUM_WIDTH + CNT_W;
    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [1:0]       mode_arr  [NUM_CHANNELS];
    logic [CNT_W-1:0] count_arr [NUM_CHANNELS];

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
            assign mode_arr[gi]  = req_mode[2*gi +: 2];
            assign count_arr[gi] = unsat_count[CNT_W*gi +: CNT_W];
        end
    endgenerate

    // ---------------- arbitration ----------------
    logic                    stage_en;
    logic                    ready_en_reg;
    logic [CH_W-1:0]         grant_ptr_reg;
    logic [CH_W-1:0]         grant_ch;
    logic                    grant_found;
    logic                    accept;
    int unsigned             scan_ch;
    logic [NUM_CHANNELS-1:0] scan_vec;

    assign stage_en = !sel_valid || sel_ready;

    always_comb begin
        grant_ch    = '0;
        grant_found = 1'b0;
        scan_ch     = 0;
        scan_vec    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            scan_ch  = (int'(grant_ptr_reg) + i) % NUM_CHANNELS;
            scan_vec = req_valid >> scan_ch;
            if (!grant_found && scan_vec[0]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'(scan_ch);
            end
        end
    end

    assign accept = ready_en_reg && stage_en && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg  <= 1'b0;
            grant_ptr_reg <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept) begin
                grant_ptr_reg <= (int'(grant_ch) == NUM_CHANNELS - 1) ? '0 : grant_ch + 1'b1;
            end
        end
    end

    // ---------------- accept-time sampling ----------------
    logic [1:0]        acc_mode;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_empty;
    logic [LFSR_W-1:0] lfsr_q;
    logic [PROD_W-1:0] acc_product;

    assign acc_mode    = mode_arr[grant_ch];
    assign acc_count   = count_arr[grant_ch];
    assign acc_empty   = (acc_count == '0);
    assign acc_product = PROD_W'(lfsr_q[RANDOM_NUM_WIDTH-1:0]) * PROD_W'(acc_count);

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (accept),
        .load      (seed_wr),
        .load_data ((seed_data == '0) ? LFSR_SEED : seed_data),
        .q         (lfsr_q)
    );

    logic unused_bits;
    assign unused_bits = ^{lfsr_q, acc_product};

    // ---------------- round-robin pointers ----------------
    logic [ADDR_W-1:0] rr_ptr_reg [NUM_CHANNELS];
    logic [ADDR_W-1:0] rr_eff;
    logic [CNT_W-1:0]  rr_inc;
    logic [ADDR_W-1:0] rr_ptr_next;
    logic              rr_update;

    // A count that shrank below the stored pointer restarts the walk at 0
    always_comb begin
        rr_eff      = ({1'b0, rr_ptr_reg[grant_ch]} >= acc_count) ? '0 : rr_ptr_reg[grant_ch];
        rr_inc      = {1'b0, rr_eff} + 1'b1;
        rr_ptr_next = (rr_inc == acc_count) ? '0 : rr_inc[ADDR_W-1:0];
    end

    assign rr_update = accept && (acc_mode == MODE_RR) && !acc_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                rr_ptr_reg[i] <= '0;
            end
        end else if (rr_update) begin
            rr_ptr_reg[grant_ch] <= rr_ptr_next;
        end
    end

    // ---------------- stage 2 ----------------
    logic              s2_valid_reg;
    logic [CH_W-1:0]   s2_channel_reg;
    logic [1:0]        s2_mode_reg;
    logic              s2_empty_reg;
    logic [ADDR_W-1:0] s2_rr_index_reg;
    logic [ADDR_W-1:0] s2_rand_index_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg      <= 1'b0;
            s2_channel_reg    <= '0;
            s2_mode_reg       <= MODE_RANDOM;
            s2_empty_reg      <= 1'b0;
            s2_rr_index_reg   <= '0;
            s2_rand_index_reg <= '0;
        end else if (stage_en) begin
            s2_valid_reg      <= accept;
            s2_channel_reg    <= grant_ch;
            s2_mode_reg       <= acc_mode;
            s2_empty_reg      <= acc_empty;
            s2_rr_index_reg   <= rr_eff;
            s2_rand_index_reg <= acc_product[RANDOM_NUM_WIDTH +: ADDR_W];
        end
    end

    // ---------------- output register ----------------
    logic              sel_valid_reg;
    logic [CH_W-1:0]   sel_channel_reg;
    logic [ADDR_W-1:0] sel_index_reg;
    logic              sel_empty_reg;
    logic [ADDR_W-1:0] index_next;

    always_comb begin
        index_next = '0;
        if (!s2_empty_reg) begin
            case (s2_mode_reg)
                MODE_RR:     index_next = s2_rr_index_reg;
                MODE_OLDEST: index_next = '0;
                default:     index_next = s2_rand_index_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid_reg   <= 1'b0;
            sel_channel_reg <= '0;
            sel_index_reg   <= '0;
            sel_empty_reg   <= 1'b0;
        end else if (stage_en) begin
            sel_valid_reg   <= s2_valid_reg;
            sel_channel_reg <= s2_channel_reg;
            sel_index_reg   <= index_next;
            sel_empty_reg   <= s2_valid_reg && s2_empty_reg;
        end
    end

    assign sel_valid   = sel_valid_reg;
    assign sel_channel = sel_channel_reg;
    assign sel_index   = sel_index_reg;
    assign sel_empty   = sel_empty_reg;
    assign sel_addr    = {sel_channel_reg, sel_index_reg};

endmodule

// File: tb/tb_unsat_clause_index_selector.sv
// Scoreboard bench for unsat_clause_index_selector: directed vectors push
// expected results, a negedge monitor pops and compares on each transfer.
module tb_unsat_clause_index_selector;
    import unsat_clause_index_selector_pkg::*;

    localparam int NC     = 4;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 12;
    localparam int CH_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NC-1:0]          req_valid;
    logic [NC-1:0]          req_ready;
    logic [2*NC-1:0]        req_mode;
    logic [NC*CNT_W-1:0]    unsat_count;
    logic                   seed_wr;
    logic [31:0]            seed_data;
    logic                   sel_valid;
    logic                   sel_ready;
    logic [CH_W-1:0]        sel_channel;
    logic [ADDR_W-1:0]      sel_index;
    logic [CH_W+ADDR_W-1:0] sel_addr;
    logic                   sel_empty;

    always #5 clk = ~clk;

    unsat_clause_index_selector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .unsat_count (unsat_count),
        .seed_wr     (seed_wr),
        .seed_data   (seed_data),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .sel_channel (sel_channel),
        .sel_index   (sel_index),
        .sel_addr    (sel_addr),
        .sel_empty   (sel_empty)
    );

    typedef struct {
        int    ch;
        int    idx;
        bit    empty;
        bit    bound_only;
        int    bound;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: one comparison set per transfer
    always @(negedge clk) begin
        if (rst_n && sel_valid && sel_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got ch=%0d idx=%0d, expected no result", sel_channel, sel_index);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_ch"}, sel_channel, mon_e.ch);
                check({mon_e.name, "_empty"}, sel_empty, mon_e.empty);
                if (mon_e.bound_only) begin
                    check({mon_e.name, "_in_range"}, (int'(sel_index) < mon_e.bound) ? 1 : 0, 1);
                end else begin
                    check({mon_e.name, "_idx"}, sel_index, mon_e.idx);
                    check({mon_e.name, "_addr"}, sel_addr, (mon_e.ch << ADDR_W) | mon_e.idx);
                end
                $display("result %s ch=%0d idx=%0d empty=%0d", mon_e.name, sel_channel, sel_index, sel_empty);
            end
        end
    end

    task automatic set_ch(input int ch, input logic [1:0] mode, input int count);
        req_mode[2*ch +: 2]          = mode;
        unsat_count[CNT_W*ch +: CNT_W] = CNT_W'(count);
    endtask

    task automatic issue(input int ch, input logic [1:0] mode, input int count, input bit push,
                         input int idx, input bit empty, input bit bound_only, input string name);
        bit   ok = 1'b0;
        exp_t e;
        set_ch(ch, mode, count);
        req_valid[ch] = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready[ch]) ok = 1'b1;
        end
        check({name, "_granted"}, ok, 1);
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
        if (push && ok) begin
            e.ch = ch; e.idx = idx; e.empty = empty; e.bound_only = bound_only; e.bound = count; e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic issue_exp(input int ch, input logic [1:0] mode, input int count,
                             input int idx, input bit empty, input string name);
        issue(ch, mode, count, 1'b1, idx, empty, 1'b0, name);
    endtask

    task automatic reseed(input logic [31:0] value);
        seed_wr   = 1'b1;
        seed_data = value;
        @(posedge clk);
        #1;
        seed_wr   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check({name, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    logic [CH_W+ADDR_W-1:0] snap_addr;
    logic                   snap_empty;
    bit                     seen;

    initial begin
        rst_n       = 1'b0;
        req_valid   = '1;
        req_mode    = '0;
        unsat_count = '0;
        seed_wr     = 1'b0;
        seed_data   = '0;
        sel_ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_sel_index", sel_index, 0);
        check("rst_sel_addr", sel_addr, 0);
        check("rst_sel_empty", sel_empty, 0);
        check("rst_sel_channel", sel_channel, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // r = 0x20000, N = 2048 -> 1024, visible two cycles after accept
        reseed(32'h0002_0000);
        issue_exp(0, MODE_RANDOM, 2048, 1024, 1'b0, "rand_half");
        @(negedge clk);
        check("latency_cycle1_valid", sel_valid, 0);
        @(negedge clk);
        check("latency_cycle2_valid", sel_valid, 1);
        check("rand_half_addr_direct", sel_addr, 1024);
        drain("t_half");

        // Random-mode boundaries and reseed behaviour
        reseed(32'h0003_FFFF);
        issue_exp(0, MODE_RANDOM, 2048, 2047, 1'b0, "rand_max");
        reseed(32'h0003_FFFF);
        issue_exp(2, 2'b11, 2048, 2047, 1'b0, "mode11_rand");
        reseed(32'h0003_FFFF);
        issue_exp(3, MODE_RANDOM, 1, 0, 1'b0, "rand_n1");
        reseed(32'h0000_0000);                       // falls back to 0xACE12468, r=0x12468
        issue_exp(1, MODE_RANDOM, 7, 1, 1'b0, "seed_zero");
        reseed(32'h0003_FFFF);
        seed_wr   = 1'b1;
        seed_data = 32'h0000_0001;
        issue_exp(0, MODE_RANDOM, 2048, 2047, 1'b0, "seed_same_cycle");
        seed_wr   = 1'b0;
        issue_exp(0, MODE_RANDOM, 2048, 0, 1'b0, "seed_wins");
        issue_exp(2, MODE_OLDEST, 5, 0, 1'b0, "oldest");
        drain("t_rand");

        // Round-robin on channel 1
        for (int i = 0; i < 5; i++) issue_exp(1, MODE_RR, 3, i % 3, 1'b0, "rr_n3");
        issue_exp(1, MODE_RR, 1, 0, 1'b0, "rr_shrunk");
        issue_exp(1, MODE_RR, 1, 0, 1'b0, "rr_shrunk2");
        issue_exp(1, MODE_RR, 3, 0, 1'b0, "rr_regrow");
        issue_exp(1, MODE_RR, 0, 0, 1'b1, "rr_empty");
        issue_exp(1, MODE_RANDOM, 0, 0, 1'b1, "rand_empty");
        issue_exp(1, MODE_OLDEST, 0, 0, 1'b1, "oldest_empty");
        issue_exp(1, MODE_RR, 3, 1, 1'b0, "rr_after_empty");
        issue_exp(1, MODE_RR, 3, 2, 1'b0, "rr_wrap");
        issue_exp(1, MODE_RR, 3, 0, 1'b0, "rr_wrapped");
        drain("t_rr");

        // Continuous requests on all channels: grants 0,1,2,3,0 one per cycle
        issue_exp(3, MODE_OLDEST, 9, 0, 1'b0, "arb_prime");
        for (int c = 0; c < NC; c++) set_ch(c, MODE_OLDEST, 4);
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            exp_t e;
            @(negedge clk);
            check("arb_grant", req_ready, 1 << (n % 4));
            e.ch = n % 4; e.idx = 0; e.empty = 1'b0; e.bound_only = 1'b0; e.bound = 4; e.name = "arb";
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain("t_arb");

        // Stall: outputs hold, no grants, no LFSR step
        reseed(32'h0003_FFFF);
        sel_ready = 1'b0;
        issue_exp(2, MODE_RANDOM, 2048, 2047, 1'b0, "stall_first");
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (sel_valid) seen = 1'b1;
        end
        check("stall_valid_seen", seen, 1);
        snap_addr  = sel_addr;
        snap_empty = sel_empty;
        set_ch(3, MODE_RANDOM, 2048);
        req_valid[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid_hold", sel_valid, 1);
            check("stall_addr_hold", sel_addr, snap_addr);
            check("stall_empty_hold", sel_empty, snap_empty);
            check("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        sel_ready = 1'b1;
        issue_exp(3, MODE_RANDOM, 2048, 1023, 1'b0, "no_step_in_stall");
        drain("t_stall");

        // Random counts: index must stay below the count
        for (int i = 0; i < 120; i++) begin
            int ch;
            int cnt;
            ch  = $urandom_range(0, 3);
            cnt = (i % 4 == 0) ? 7 : $urandom_range(1, 2048);
            issue(ch, MODE_RANDOM, cnt, 1'b1, 0, 1'b0, 1'b1, "rand_bound");
        end
        drain("t_bulk");

        // Reset with two results in flight
        sel_ready = 1'b0;
        issue(0, MODE_RANDOM, 100, 1'b0, 0, 1'b0, 1'b0, "inflight_a");
        issue(1, MODE_RANDOM, 100, 1'b0, 0, 1'b0, 1'b0, "inflight_b");
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("inflight_rst_valid", sel_valid, 0);
        check("inflight_rst_req_ready", req_ready, 0);
        check("inflight_rst_addr", sel_addr, 0);
        repeat (2) @(posedge clk); #1;
        req_valid = '0;
        sel_ready = 1'b1;
        rst_n = 1'b1;
        issue_exp(0, MODE_RANDOM, 2048, 584, 1'b0, "post_reset_seed");
        issue_exp(1, MODE_RR, 3, 0, 1'b0, "post_reset_rr");
        drain("t_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
